// File: rtl/tristate_mon_pkg.sv
// Shared types and defaults for the tristate sample monitor.
//   mon_state_t      : run-control FSM state
//   CNT_W_DEF        : default counter width
//   NUM_SAMPLES_DEF  : default samples per run
package tristate_mon_pkg;
  localparam int CNT_W_DEF       = 16;
  localparam int NUM_SAMPLES_DEF = 10000;

  typedef enum logic [1:0] {IDLE, RUN, DONE} mon_state_t;
endpackage

// File: rtl/tristate_edge_sync.sv
// Input register stage for the DUT's en/a/b plus the en rise detector.
//   clk, rst : clock, async active-high reset
//   en, a, b : raw DUT enable, driven value, observed value
//   rise     : high for one cycle after en is first sampled high
//   a_s1     : a sampled on the same edge as the en rise
//   b_s1     : b sampled on the same edge as the en rise
module tristate_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic a,
  input  logic b,
  output logic rise,
  output logic a_s1,
  output logic b_s1
);
  logic en_s1_q, en_s2_q, a_s1_q, b_s1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_s1_q <= 1'b0;
      en_s2_q <= 1'b0;
      a_s1_q  <= 1'b0;
      b_s1_q  <= 1'b0;
    end else begin
      en_s1_q <= en;
      en_s2_q <= en_s1_q;
      a_s1_q  <= a;
      b_s1_q  <= b;
    end
  end

  assign rise = en_s1_q & ~en_s2_q;
  assign a_s1 = a_s1_q;
  assign b_s1 = b_s1_q;
endmodule

// File: rtl/tristate_sample_monitor.sv
// Downstream checker: on each en rise compares a against b, counts samples
// and mismatches, records the first mismatch index, and flags done/pass/fail
// after NUM_SAMPLES samples.
//   clk, rst        : clock, async active-high reset
//   start           : pulse; clears counters and begins a run (IDLE/DONE only)
//   en, a, b        : DUT enable, driven value, observed value
//   busy, done      : run in progress / run complete
//   pass, fail      : done with no mismatch / sticky mismatch seen
//   sample_cnt      : samples taken this run
//   err_cnt         : mismatches, saturating
//   first_err_idx   : 0-based index of first mismatch (valid with first_err_vld)
module tristate_sample_monitor
  import tristate_mon_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int NUM_SAMPLES = NUM_SAMPLES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             en,
  input  logic             a,
  input  logic             b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_err_idx,
  output logic             first_err_vld
);
  localparam logic [CNT_W-1:0] N_C = CNT_W'(NUM_SAMPLES);

  logic rise, a_s1, b_s1;

  tristate_edge_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .a    (a),
    .b    (b),
    .rise (rise),
    .a_s1 (a_s1),
    .b_s1 (b_s1)
  );

  mon_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, err_q, err_d, idx_q, idx_d;
  logic             fail_q, fail_d, fev_q, fev_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    idx_d   = idx_q;
    fail_d  = fail_q;
    fev_d   = fev_q;
    case (state_q)
      IDLE, DONE: begin
        // A rise coinciding with start is dropped; the clear wins.
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          err_d   = '0;
          idx_d   = '0;
          fail_d  = 1'b0;
          fev_d   = 1'b0;
        end
      end
      RUN: begin
        // Leave RUN the cycle after the final sample lands, so done
        // trails the last counter update by one cycle.
        if (cnt_q == N_C) begin
          state_d = DONE;
        end else if (rise) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (a_s1 != b_s1) begin
            if (err_q != '1) err_d = err_q + CNT_W'(1);
            fail_d = 1'b1;
            if (!fev_q) begin
              fev_d = 1'b1;
              idx_d = cnt_q;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= '0;
      idx_q   <= '0;
      fail_q  <= 1'b0;
      fev_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      fail_q  <= fail_d;
      fev_q   <= fev_d;
    end
  end

  assign busy          = (state_q == RUN);
  assign done          = (state_q == DONE);
  assign pass          = done & ~fail_q;
  assign fail          = fail_q;
  assign sample_cnt    = cnt_q;
  assign err_cnt       = err_q;
  assign first_err_idx = idx_q;
  assign first_err_vld = fev_q;
endmodule

// File: tb/tb_tristate_sample_monitor.sv
module tb_tristate_sample_monitor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0, a = 1'b0, b = 1'b0;
  logic start5 = 1'b0, start8 = 1'b0, start7 = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // N=5 instance
  logic        busy5, done5, pass5, fail5, fev5;
  logic [15:0] cnt5, err5, idx5;
  tristate_sample_monitor #(.CNT_W(16), .NUM_SAMPLES(5)) u5 (
    .clk(clk), .rst(rst), .start(start5), .en(en), .a(a), .b(b),
    .busy(busy5), .done(done5), .pass(pass5), .fail(fail5),
    .sample_cnt(cnt5), .err_cnt(err5), .first_err_idx(idx5), .first_err_vld(fev5));

  // N=8 instance
  logic        busy8, done8, pass8, fail8, fev8;
  logic [15:0] cnt8, err8, idx8;
  tristate_sample_monitor #(.CNT_W(16), .NUM_SAMPLES(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .en(en), .a(a), .b(b),
    .busy(busy8), .done(done8), .pass(pass8), .fail(fail8),
    .sample_cnt(cnt8), .err_cnt(err8), .first_err_idx(idx8), .first_err_vld(fev8));

  // CNT_W=3, N=7 instance
  logic       busy7, done7, pass7, fail7, fev7;
  logic [2:0] cnt7, err7, idx7;
  tristate_sample_monitor #(.CNT_W(3), .NUM_SAMPLES(7)) u7 (
    .clk(clk), .rst(rst), .start(start7), .en(en), .a(a), .b(b),
    .busy(busy7), .done(done7), .pass(pass7), .fail(fail7),
    .sample_cnt(cnt7), .err_cnt(err7), .first_err_idx(idx7), .first_err_vld(fev7));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One sample: en high for one cycle with a/b, then low for two.
  task automatic pulse(input logic av, input logic bv);
    @(negedge clk); en = 1'b1; a = av; b = bv;
    @(negedge clk); en = 1'b0;
    @(negedge clk);
  endtask

  task automatic go(input int which);
    @(negedge clk);
    if (which == 5) start5 = 1'b1;
    if (which == 8) start8 = 1'b1;
    if (which == 7) start7 = 1'b1;
    @(negedge clk);
    start5 = 1'b0; start8 = 1'b0; start7 = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    // reset state
    chk("rst_busy", busy5, 0); chk("rst_done", done5, 0);
    chk("rst_pass", pass5, 0); chk("rst_fail", fail5, 0);
    chk("rst_cnt", cnt5, 0);   chk("rst_err", err5, 0);
    chk("rst_idx", idx5, 0);   chk("rst_fev", fev5, 0);
    rst = 1'b0;

    // rises before start are ignored
    pulse(1'b1, 1'b0); pulse(1'b0, 1'b0);
    chk("pre_cnt", cnt5, 0); chk("pre_busy", busy5, 0);

    // clean run of 5
    go(5);
    chk("run_busy", busy5, 1);
    pulse(1'b0, 1'b0); pulse(1'b1, 1'b1); pulse(1'b1, 1'b1);
    pulse(1'b0, 1'b0); pulse(1'b1, 1'b1);
    repeat (2) @(negedge clk);
    chk("ok_cnt", cnt5, 5);  chk("ok_done", done5, 1);
    chk("ok_pass", pass5, 1); chk("ok_err", err5, 0);
    chk("ok_fev", fev5, 0);  chk("ok_busy", busy5, 0);
    chk("ok_fail", fail5, 0);

    // rise after done is ignored
    pulse(1'b1, 1'b0);
    chk("post_cnt", cnt5, 5); chk("post_done", done5, 1); chk("post_err", err5, 0);

    // start coincident with a rise in DONE: rise lands on the start edge
    @(negedge clk); en = 1'b1; a = 1'b1; b = 1'b0;
    @(negedge clk); start5 = 1'b1;
    @(negedge clk); start5 = 1'b0; en = 1'b0;
    chk("coin_cnt", cnt5, 0); chk("coin_err", err5, 0);
    chk("coin_busy", busy5, 1); chk("coin_done", done5, 0);
    @(negedge clk);
    chk("coin_cnt2", cnt5, 0);

    // N=8 with mismatches on samples 2 and 5
    go(8);
    for (int k = 0; k < 8; k++) begin
      if (k == 2 || k == 5) pulse(1'b1, 1'b0); else pulse(1'b1, 1'b1);
      if (k == 2) begin
        chk("mid_err", err8, 1); chk("mid_fev", fev8, 1); chk("mid_fail", fail8, 1);
      end
      if (k == 6) chk("mid_done", done8, 0);
    end
    repeat (2) @(negedge clk);
    chk("mm_cnt", cnt8, 8);  chk("mm_err", err8, 2);
    chk("mm_idx", idx8, 2);  chk("mm_fev", fev8, 1);
    chk("mm_fail", fail8, 1); chk("mm_pass", pass8, 0);
    chk("mm_done", done8, 1);

    // CNT_W=3, N=7, every sample mismatched
    go(7);
    for (int k = 0; k < 7; k++) pulse(k[0], ~k[0]);
    repeat (2) @(negedge clk);
    chk("sat_err", err7, 7); chk("sat_done", done7, 1);
    chk("sat_cnt", cnt7, 7); chk("sat_idx", idx7, 0);
    chk("sat_fail", fail7, 1);

    // async reset between edges after 3 samples
    go(8);
    pulse(1'b1, 1'b0); pulse(1'b1, 1'b1); pulse(1'b0, 1'b0);
    chk("ar_cnt_pre", cnt8, 3);
    #1 rst = 1'b1;
    #1;
    chk("ar_busy", busy8, 0); chk("ar_done", done8, 0);
    chk("ar_pass", pass8, 0); chk("ar_fail", fail8, 0);
    chk("ar_cnt", cnt8, 0);   chk("ar_err", err8, 0);
    chk("ar_idx", idx8, 0);   chk("ar_fev", fev8, 0);
    #1 rst = 1'b0;
    go(8);
    chk("ar_busy2", busy8, 1); chk("ar_cnt2", cnt8, 0);
    pulse(1'b0, 1'b0);
    chk("ar_cnt3", cnt8, 1); chk("ar_err3", err8, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
